// File: rtl/core_pkg.sv
// Shared core-wide constants and the fetch-entry record handed from fetch to decode.
package core_pkg;

    localparam int INSTR_W   = 32;
    localparam int PC_STEP   = 4;
    localparam int CORE_XLEN = 32;

    // Field order matches the {pc, instr} packing used inside the fetch queue.
    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [INSTR_W-1:0]   instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush; head data is read combinationally from storage.
module fetch_queue
    import core_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign head_data = mem[head_ptr];
    assign do_pop    = pop & !empty;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_push   = push & (!full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            // NOTE: storage is cleared on reset because the head entry is visible on the outputs even when empty.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                mem[tail_ptr] <= push_data;
                tail_ptr      <= tail_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory and
// buffers {pc, instr} pairs for decode; an execute-stage redirect reloads the PC and flushes.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_pc_plus4
);

    localparam int              ENTRY_W = XLEN + INSTR_W;
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

    logic [XLEN-1:0]    pc;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic [ENTRY_W-1:0] head_entry;

    assign pop  = out_valid & out_ready;
    // out_ready feeds the push decision so a full queue still streams one per cycle.
    assign push = !redirect_valid & (!full | pop);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + STEP;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pc, imem_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (full),
        .empty     (empty),
        .head_data (head_entry)
    );

    assign imem_addr    = pc;
    assign out_valid    = !empty;
    assign out_pc       = head_entry[ENTRY_W-1:INSTR_W];
    assign out_instr    = head_entry[INSTR_W-1:0];
    assign out_pc_plus4 = out_pc + STEP;

endmodule
